// File: rtl/uart_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_bridge_pkg
// Shared types and constants for the UART echo bridge:
//   bridge_state_e : command-decoder state (PASS = echo data, CMD = after ESC)
//   CMD_*          : command codes recognised after an escape byte
//   sat_inc16      : saturating 16-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package uart_bridge_pkg;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    CMD  = 1'b1
  } bridge_state_e;

  localparam logic [7:0] CMD_CORE_OFF = 8'h00;
  localparam logic [7:0] CMD_CORE_ON  = 8'h01;
  localparam logic [7:0] CMD_CLR_OVF  = 8'h02;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock show-ahead FIFO: the head word is visible on head_data whenever
// the FIFO is non-empty, and pop advances to the next word on the clock edge.
// A push on a full FIFO is accepted only if a pop happens in the same cycle;
// otherwise the word is dropped and 'drop' is raised for that cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and data
//   pop               read request (ignored while empty)
//   head_data         current head word, zero while empty
//   full, empty       occupancy flags
//   level             occupancy 0..DEPTH
//   drop              push refused this cycle (full and no pop)
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          full_s, empty_s, do_push_s, do_pop_s;

  assign full_s    = (level_q == LW'(DEPTH));
  assign empty_s   = (level_q == '0);
  assign do_pop_s  = pop && !empty_s;
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign do_push_s = push && (!full_s || do_pop_s);

  // Next-state for pointers and the occupancy counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head word is forced to zero while empty so stale data never shows.
  always_comb begin
    if (empty_s) begin
      head_data = '0;
    end else begin
      head_data = mem_q[rd_ptr_q];
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign level = level_q;
  assign drop  = push && full_s && !do_pop_s;

endmodule

// File: rtl/uart_echo_bridge.sv
// -----------------------------------------------------------------------------
// uart_echo_bridge
// RX->TX echo path with an escape-coded command channel. Received words are
// queued in a show-ahead FIFO and offered to TX. An ESC_BYTE opens a command:
//   ESC ESC -> literal ESC echoed     ESC 01 -> core_en = 1
//   ESC 00  -> core_en = 0            ESC 02 -> clear overflow (and drop_cnt)
//   ESC <other> -> ignored
// Optional feature macro: UART_ECHO_STATS_EN adds rx_cnt/tx_cnt/drop_cnt.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     received word and its one-cycle strobe
//   tx_data, tx_valid     FIFO head and non-empty flag
//   tx_ready              TX accepts the head when tx_valid && tx_ready
//   core_en               sticky enable set/cleared by commands
//   overflow              sticky: a word was dropped on a full FIFO
//   fifo_level            current FIFO occupancy
//   last_tx               last word handed to TX
//   rx_cnt/tx_cnt/drop_cnt  saturating statistics (macro builds only)
// -----------------------------------------------------------------------------
module uart_echo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         DW       = 8,
  parameter int         DEPTH    = 16,
  parameter logic [7:0] ESC_BYTE = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          rx_data,
  input  logic                   rx_valid,
  output logic [DW-1:0]          tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   core_en,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level,
`ifdef UART_ECHO_STATS_EN
  output logic [15:0]            rx_cnt,
  output logic [15:0]            tx_cnt,
  output logic [15:0]            drop_cnt,
`endif
  output logic [DW-1:0]          last_tx
);

  localparam logic [DW-1:0] ESC_W = DW'(ESC_BYTE);

  bridge_state_e  state_q, state_d;
  logic           core_en_q, core_en_d;
  logic           overflow_q, overflow_d;
  logic [DW-1:0]  last_tx_q, last_tx_d;
  logic           push_s, pop_s, clr_drop_s;
  logic [DW-1:0]  push_data_s;
  logic [DW-1:0]  head_s;
  logic           full_s, empty_s, drop_s;
  logic [$clog2(DEPTH):0] level_s;

  uart_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s),
    .drop      (drop_s)
  );

  assign pop_s = !empty_s && tx_ready;

  // Command decoder, FIFO write request and flag next-state.
  always_comb begin
    state_d     = state_q;
    core_en_d   = core_en_q;
    overflow_d  = overflow_q;
    push_s      = 1'b0;
    push_data_s = '0;
    clr_drop_s  = 1'b0;
    if (rx_valid) begin
      case (state_q)
        PASS: begin
          if (rx_data == ESC_W) begin
            state_d = CMD;
          end else begin
            push_s      = 1'b1;
            push_data_s = rx_data;
          end
        end
        CMD: begin
          // Every command byte, recognised or not, closes the escape.
          state_d = PASS;
          case (rx_data[7:0])
            ESC_BYTE: begin
              push_s      = 1'b1;
              push_data_s = ESC_W;
            end
            CMD_CORE_ON:  core_en_d = 1'b1;
            CMD_CORE_OFF: core_en_d = 1'b0;
            CMD_CLR_OVF: begin
              overflow_d = 1'b0;
              clr_drop_s = 1'b1;
            end
            default: state_d = PASS;
          endcase
        end
        default: state_d = PASS;
      endcase
    end else begin
      state_d = state_q;
    end
    // A drop only arises from a push, so it never coincides with a clear.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_d;
    end
    if (pop_s) begin
      last_tx_d = head_s;
    end else begin
      last_tx_d = last_tx_q;
    end
  end

  // FSM state and registered flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PASS;
      core_en_q  <= 1'b0;
      overflow_q <= 1'b0;
      last_tx_q  <= '0;
    end else begin
      state_q    <= state_d;
      core_en_q  <= core_en_d;
      overflow_q <= overflow_d;
      last_tx_q  <= last_tx_d;
    end
  end

  assign tx_data    = head_s;
  assign tx_valid   = !empty_s;
  assign core_en    = core_en_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_s;
  assign last_tx    = last_tx_q;

`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating statistics counters next-state.
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (rx_valid) begin
      rx_cnt_d = sat_inc16(rx_cnt_q);
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
    if (pop_s) begin
      tx_cnt_d = sat_inc16(tx_cnt_q);
    end else begin
      tx_cnt_d = tx_cnt_q;
    end
    if (clr_drop_s) begin
      drop_cnt_d = 16'd0;
    end else if (drop_s) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= 16'd0;
      tx_cnt_q   <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_cnt   = rx_cnt_q;
  assign tx_cnt   = tx_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_echo_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_bridge
// Scoreboard bench: every word expected on TX is queued when it is sent, and
// the TX monitor pops and compares on each handshake. Flag and level outputs
// are compared against constants at fixed points of each scenario.
// -----------------------------------------------------------------------------
module tb_uart_echo_bridge;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          core_en;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] last_tx;
`ifdef UART_ECHO_STATS_EN
  logic [15:0]   rx_cnt, tx_cnt, drop_cnt;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  uart_echo_bridge #(.DW(DW), .DEPTH(DEPTH), .ESC_BYTE(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .core_en    (core_en),
    .overflow   (overflow),
    .fifo_level (fifo_level),
`ifdef UART_ECHO_STATS_EN
    .rx_cnt     (rx_cnt),
    .tx_cnt     (tx_cnt),
    .drop_cnt   (drop_cnt),
`endif
    .last_tx    (last_tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // TX monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("tx_unexpected", 32'(tx_valid), 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check_eq("tx_data", 32'(tx_data), 32'(mon_exp));
      end
    end
  end

  // One rx strobe; queue the word on the scoreboard if it should reach TX.
  task automatic send(input logic [DW-1:0] d, input bit exp_push);
    rx_data  = d;
    rx_valid = 1'b1;
    if (exp_push) sb_q.push_back(d);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Let TX drain with a bounded wait, then confirm nothing is outstanding.
  task automatic drain(input string tag);
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && !tx_valid) break;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check_eq({tag, "_core_en"},  32'(core_en),  32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, "_level"},    32'(fifo_level), 32'd0);
    check_eq({tag, "_last_tx"},  32'(last_tx),  32'd0);
`ifdef UART_ECHO_STATS_EN
    check_eq({tag, "_rx_cnt"},   32'(rx_cnt),   32'd0);
    check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: plain echo in order
    tx_ready = 1'b1;
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    send(8'h43, 1'b1);
    drain("t1");
    check_eq("t1_last_tx", 32'(last_tx), 32'h43);
    check_eq("t1_level", 32'(fifo_level), 32'd0);

    // 2: core enable on/off, no TX traffic
    send(8'hFF, 1'b0);
    send(8'h01, 1'b0);
    check_eq("t2_core_on", 32'(core_en), 32'd1);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    check_eq("t2_core_off", 32'(core_en), 32'd0);
    drain("t2");

    // 3: escaped literal, unknown command ignored, back in PASS
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    send(8'h7E, 1'b1);
    send(8'hFF, 1'b0);
    send(8'h55, 1'b0);
    send(8'h33, 1'b1);
    drain("t3");
    check_eq("t3_last_tx", 32'(last_tx), 32'h33);

    // 4: overflow with TX stalled, then clear via command
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) send(DW'(8'h10 + i), (i < 16));
    check_eq("t4_level_full", 32'(fifo_level), 32'd16);
    check_eq("t4_overflow", 32'(overflow), 32'd1);
    check_eq("t4_head_held", 32'(tx_data), 32'h10);
`ifdef UART_ECHO_STATS_EN
    check_eq("t4_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    send(8'hFF, 1'b0);
    send(8'h02, 1'b0);
    check_eq("t4_overflow_clr", 32'(overflow), 32'd0);
    check_eq("t4_level_kept", 32'(fifo_level), 32'd16);
`ifdef UART_ECHO_STATS_EN
    check_eq("t4_drop_clr", 32'(drop_cnt), 32'd0);
`endif

    // 5: push and pop together on a full FIFO
    tx_ready = 1'b1;
    send(8'hA5, 1'b1);
    tx_ready = 1'b0;
    check_eq("t5_level", 32'(fifo_level), 32'd16);
    check_eq("t5_overflow", 32'(overflow), 32'd0);
    check_eq("t5_head_next", 32'(tx_data), 32'h11);
    tx_ready = 1'b1;
    drain("t5");
    check_eq("t5_last_tx", 32'(last_tx), 32'hA5);

    // 6: reset in the middle of a command with words queued
    send(8'hFF, 1'b0);
    send(8'h01, 1'b0);
    check_eq("t6_core_on", 32'(core_en), 32'd1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(DW'(8'h60 + i), 1'b0);
    send(8'hFF, 1'b0);
    check_eq("t6_level_pre", 32'(fifo_level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("t6_in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    send(8'h01, 1'b1);
    drain("t6");
    check_eq("t6_core_stays", 32'(core_en), 32'd0);
    check_eq("t6_last_tx", 32'(last_tx), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
